// File: rtl/add_serial_ctrl_pkg.sv
// add_serial_ctrl_pkg: FSM state encodings and op codes shared by the serial and parallel ALU paths
package add_serial_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_serial_ctrl_add_1bit.sv
// add_1bit: full-adder cell (a, b, carry-in c -> sum, carry)
module add_1bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: bit-serial add/sub over one add_1bit cell; start/op/a/b in, busy/done/result/cout/zf/sf/of out
module add_serial_ctrl
  import add_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, res_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic sum, cy;
  add_1bit u_add (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .c    (carry_q),
    .sum  (sum),
    .carry(cy)
  );
  assign res_sh = {sum, res_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        sa_d    = a;
        sb_d    = (op == OP_ADD) ? b : ~b;
        carry_d = (op == OP_SUB);
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = res_sh;
        carry_d = cy;
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cout_d  = cy;
          zf_d    = (res_sh == '0);
          sf_d    = sum;
          of_d    = carry_q ^ cy;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign zf     = zf_q;
  assign sf     = sf_q;
  assign of     = of_q;
endmodule

// File: tb/tb_add_serial_ctrl.sv
// tb_add_serial_ctrl: directed and random add/sub checks of 64- and 8-bit instances against an arithmetic model
module tb_add_serial_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start64 = 1'b0, op64 = 1'b0, start8 = 1'b0, op8 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic [7:0] a8 = '0, b8 = '0, res8;
  logic busy64, done64, cout64, zf64, sf64, of64;
  logic busy8, done8, cout8, zf8, sf8, of8;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  add_serial_ctrl #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .op(op64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .result(res64), .cout(cout64), .zf(zf64), .sf(sf64), .of(of64)
  );
  add_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .zf(zf8), .sf(sf8), .of(of8)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Called at the negedge right after the accepting edge; waits for done and checks everything.
  task automatic wait_check(input bit w8, input logic o, input logic [63:0] x, input logic [63:0] y, input bit scr);
    int w, n;
    logic [63:0] m, xv, yv, er;
    logic ec, eo;
    w  = w8 ? 8 : 64;
    m  = w8 ? 64'hFF : '1;
    xv = x & m;
    yv = y & m;
    er = (o ? xv - yv : xv + yv) & m;
    ec = o ? (xv >= yv) : (({1'b0, xv} + {1'b0, yv}) > {1'b0, m});
    eo = (o ? (xv[w-1] != yv[w-1]) : (xv[w-1] == yv[w-1])) && (er[w-1] != xv[w-1]);
    chk("busy_after_accept", {63'b0, w8 ? busy8 : busy64}, 64'd1);
    n = 0;
    while (!(w8 ? done8 : done64) && n < w + 20) begin
      if (scr) begin
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
        op64 = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(w));
    chk("result", w8 ? {56'b0, res8} : res64, er);
    chk("cout", {63'b0, w8 ? cout8 : cout64}, {63'b0, ec});
    chk("zf", {63'b0, w8 ? zf8 : zf64}, {63'b0, er == 0});
    chk("sf", {63'b0, w8 ? sf8 : sf64}, {63'b0, er[w-1]});
    chk("of", {63'b0, w8 ? of8 : of64}, {63'b0, eo});
  endtask
  task automatic run(input bit w8, input logic o, input logic [63:0] x, input logic [63:0] y);
    if (w8) begin
      a8 = x[7:0]; b8 = y[7:0]; op8 = o; start8 = 1'b1;
    end else begin
      a64 = x; b64 = y; op64 = o; start64 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    start64 = 1'b0;
    wait_check(w8, o, x, y, 1'b0);
    @(negedge clk);
    chk("done_single_pulse", {63'b0, w8 ? done8 : done64}, 64'd0);
    chk("idle_after_done", {63'b0, w8 ? busy8 : busy64}, 64'd0);
  endtask
  initial begin
    logic [63:0] x1, y1, x2, y2;
    int dcnt;
    #1;
    chk("rst_busy", {63'b0, busy64}, 64'd0);
    chk("rst_done", {63'b0, done64}, 64'd0);
    chk("rst_result", res64, 64'd0);
    chk("rst_flags", {60'b0, cout64, zf64, sf64, of64}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 0, 64'd5, 64'd3);
    run(0, 1, 64'd5, 64'd5);
    run(0, 1, 64'd0, 64'd1);
    run(0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    run(0, 1, 64'h8000_0000_0000_0000, 64'd1);
    run(1, 0, 64'hFF, 64'h01);
    run(1, 1, 64'h80, 64'h01);
    for (int i = 0; i < 6; i++) run(0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    for (int i = 0; i < 6; i++) run(1, 1'($urandom), 64'($urandom), 64'($urandom));
    x1 = {$urandom, $urandom}; y1 = {$urandom, $urandom};
    x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
    a64 = x1; b64 = y1; op64 = 1'b0; start64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_check(0, 0, x1, y1, 1'b1);
    a64 = x2; b64 = y2; op64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("held_first_idle_busy", {63'b0, busy64}, 64'd0);
    chk("held_first_idle_done", {63'b0, done64}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    start64 = 1'b0;
    wait_check(0, 1, x2, y2, 1'b0);
    @(negedge clk);
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; op64 = 1'b0; start64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start64 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy64}, 64'd0);
    chk("midrst_done", {63'b0, done64}, 64'd0);
    chk("midrst_result", res64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done64 || busy64) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    run(0, 0, {$urandom, $urandom}, {$urandom, $urandom});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
